// File: rtl/regfile_sb_if.sv
// Register file / scoreboard bundle: read ports, issue reservation,
// write-back and the sticky underflow flag.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_ready;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              err_underflow;

  modport master (
    output rs1_addr, rs2_addr,
    input  rs1_data, rs2_data,
    input  rs1_busy, rs2_busy,
    output issue_valid, issue_rd,
    input  issue_ready,
    output wb_en, wb_addr, wb_data,
    input  err_underflow
  );

  modport slave (
    input  rs1_addr, rs2_addr,
    output rs1_data, rs2_data,
    output rs1_busy, rs2_busy,
    input  issue_valid, issue_rd,
    output issue_ready,
    input  wb_en, wb_addr, wb_data,
    output err_underflow
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register pending-write scoreboard.
// REGFILE_BYPASS_EN forwards same-cycle write-back to the read ports.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_PEND = 3
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = $clog2(MAX_PEND + 1);
  localparam logic [PW-1:0] PMAX = PW'(MAX_PEND);
  localparam logic [PW-1:0] PONE = PW'(1);

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [PW-1:0]     pend    [DEPTH];
  logic [PW-1:0]     pendNxt [DEPTH];
  logic              err;
  logic              errSet;
  logic              issueAcc;
  logic              wbAcc;
  logic [DEPTH-1:0]  incV;
  logic [DEPTH-1:0]  decV;

  assign bus.issue_ready = (bus.issue_rd == '0) ||
                           (pend[bus.issue_rd] != PMAX);
  assign issueAcc = bus.issue_valid && bus.issue_ready &&
                    (bus.issue_rd != '0);
  assign wbAcc    = bus.wb_en && (bus.wb_addr != '0);

  assign incV = {DEPTH{issueAcc}} & (DEPTH'(1) << bus.issue_rd);
  assign decV = {DEPTH{wbAcc}}    & (DEPTH'(1) << bus.wb_addr);

  function automatic logic [DATA_W-1:0] rdData(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] d;
    d = (a == '0) ? '0 : mem[a];
`ifdef REGFILE_BYPASS_EN
    if (wbAcc && bus.wb_addr == a) d = bus.wb_data;
`endif
    return d;
  endfunction

  function automatic logic rdBusy(
    input logic [ADDR_W-1:0] a
  );
    logic b;
    b = (a != '0) && (pend[a] != '0);
`ifdef REGFILE_BYPASS_EN
    // last outstanding write lands now and nothing re-reserves it
    if (wbAcc && bus.wb_addr == a && pend[a] == PONE &&
        !(issueAcc && bus.issue_rd == a))
      b = 1'b0;
`endif
    return b;
  endfunction

  assign bus.rs1_data      = rdData(bus.rs1_addr);
  assign bus.rs2_data      = rdData(bus.rs2_addr);
  assign bus.rs1_busy      = rdBusy(bus.rs1_addr);
  assign bus.rs2_busy      = rdBusy(bus.rs2_addr);
  assign bus.err_underflow = err;

  always_comb begin
    errSet = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pendNxt[i] = pend[i];
      unique case (1'b1)
        incV[i] && !decV[i]:
          pendNxt[i] = pend[i] + PONE;
        decV[i] && !incV[i]:
          if (pend[i] == '0) errSet = 1'b1;
          else pendNxt[i] = pend[i] - PONE;
        incV[i] && decV[i]:
          if (pend[i] == '0) pendNxt[i] = PONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]  <= '0;
        pend[i] <= '0;
      end
      err <= 1'b0;
    end else begin
      if (wbAcc) mem[bus.wb_addr] <= bus.wb_data;
      for (int i = 0; i < DEPTH; i++)
        pend[i] <= pendNxt[i];
      if (errSet) err <= 1'b1;
    end
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with an integrated pending-write scoreboard for the pipelined MIPS datapath. Two asynchronous read ports, one synchronous write-back port, and an issue port that reserves destination registers. Per-register saturating pending counters give the decode stage source-busy and issue-ready signals. Register 0 is hardwired to zero and never tracked.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- MAX_PEND, 3, maximum outstanding writes per register (1..7); counter width PW = clog2(MAX_PEND+1)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset; one clock domain
- rs1_addr, rs2_addr  in  ADDR_W  read addresses
- rs1_data, rs2_data  out  DATA_W  read data
- rs1_busy, rs2_busy  out  1  source has an outstanding write not satisfied this cycle
- issue_valid  in  1  decode requests reservation of issue_rd
- issue_rd  in  ADDR_W  destination to reserve
- issue_ready  out  1  reservation can be accepted this cycle
- wb_en  in  1  write-back strobe
- wb_addr  in  ADDR_W  write-back destination
- wb_data  in  DATA_W  write-back data
- err_underflow  out  1  sticky: write-back to a tracked register with zero pending count

## Operation
- Storage: 2**ADDR_W x DATA_W array, pending counters pend[i] of PW bits, sticky err flag.
- Read: rsN_data = 0 if rsN_addr == 0, else array[rsN_addr]; bypass per Configuration.
- Write: on clk edge with wb_en and wb_addr != 0, array[wb_addr] <= wb_data. Writes to 0 are dropped, with no counter update and no error.
- issue_ready = 0 only when issue_rd != 0 and pend[issue_rd] == MAX_PEND. It ignores any same-cycle write-back credit.
- Issue accepted = issue_valid & issue_ready & (issue_rd != 0). Issues to register 0 are always ready and have no effect.
- Counter update per register i, per edge:
  - Accepted issue only: pend[i] + 1.
  - Write-back only: pend[i] - 1. If pend[i] == 0, the counter stays 0 and err is set.
  - Both on the same register: unchanged; if pend[i] was 0, the counter becomes 1, with no error.
  - Issue and write-back on different registers update independently.
- err_underflow stays set until reset.
- rsN_busy base = (rsN_addr != 0) & (pend[rsN_addr] != 0).

## Timing
- Reads, busy and issue_ready are combinational from current state and inputs, with zero latency.
- Write data and counters take effect on the rising edge after presentation. A read in the next cycle returns the new value.
- Reset (async, any time, including mid-write) gives: all array words 0, all pend 0, err 0. Outputs immediately become rsN_data = 0, rsN_busy = 0, issue_ready = 1, err_underflow = 0.
- Release of rst is synchronous to clk (external synchroniser). The first edge after release performs normal updates.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When wb_en & wb_addr == rsN_addr != 0, rsN_data = wb_data in the same cycle.
  - rsN_busy is additionally cleared when that hit occurs and pend[rsN_addr] == 1 and no accepted issue targets rsN_addr this cycle.
- Undefined: reads return the stored array value only, and busy is the base term. The consumer waits one cycle after write-back.

## Test plan
- Reset then read r0..r31: all data 0, busy 0, issue_ready 1. Write r0 = 0xDEADBEEF, then read r0: returns 0, err 0.
- Issue r5 three times (MAX_PEND=3): issue_ready for r5 drops to 0 after the third edge. Write-back r5 = 0x1234 once: ready returns to 1, rs1_busy stays 1 (pend=2).
- Issue r7; next cycle issue r7 together with write-back r7 = 0xA5A5A5A5: pend stays 1, busy 1, array r7 = 0xA5A5A5A5 read the following cycle.
- With REGFILE_BYPASS_EN, pend[r9] = 1, write-back r9 = 0x55 with rs2_addr = 9: same cycle rs2_data = 0x55, rs2_busy = 0. Without the macro: rs2_data = old value, busy = 1, then 0x55 and busy 0 the next cycle.
- Write-back r3 = 0x1 with pend[r3] = 0: data written, err_underflow = 1 from the next edge and held. Assert rst mid-cycle: err, data and pend clear immediately, without waiting for a clock.
- Random mix of issue and write-back on r1..r4 against a reference model: counters, busy, ready and data match every cycle.
